// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction fetch stage. Issues one instruction-memory request
//               at a time, buffers the response for the IF/ID register, and
//               handles redirects (trap > mret > branch), kill and WFI sleep.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    input  logic [31:0] mtvec,
    input  logic        mret,
    input  logic [31:0] mepc,
    input  logic        wfi,
    input  logic        irq_wake,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_inst,
    output logic        fetch_valid,
    output logic        waiting
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_SLEEP = 2'd3
    } state_t;

    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] c_INST_BYTES = 32'd4;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_kill;
    logic        w_kill_nxt;
    logic        r_fetch_valid;
    logic        w_fetch_valid_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_fetch_inst;

    logic        w_redir;
    logic [31:0] w_target;
    logic        w_consume;
    logic        w_issue;
    logic        w_fire;
    logic        w_load;

    assign w_redir  = trap | mret | redirect;
    assign w_target = (trap ? mtvec : (mret ? mepc : redirect_pc)) & c_ALIGN_MASK;

    assign w_consume = r_fetch_valid & ~stall;
    // Only request when the output buffer is free (or drains this cycle), so a
    // response can never arrive while the IF/ID register is still holding.
    assign w_issue   = (r_state == S_REQ) & (~r_fetch_valid | ~stall);
    assign w_fire    = w_issue & im_gnt;
    assign w_load    = (r_state == S_WAIT) & im_rvalid & ~r_kill & ~w_redir;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (w_fire) begin
                    w_state_nxt = S_WAIT;
                    if (w_redir) begin
                        w_kill_nxt = 1'b1;
                    end
                end else if (!w_redir && wfi) begin
                    w_state_nxt = S_SLEEP;
                end
            end
            S_WAIT: begin
                if (im_rvalid) begin
                    // Killed or redirected responses are dropped; the pending
                    // kill has now been matched with its response.
                    w_kill_nxt  = 1'b0;
                    w_state_nxt = (w_load && wfi) ? S_SLEEP : S_REQ;
                end else if (w_redir) begin
                    w_kill_nxt = 1'b1;
                end
            end
            S_SLEEP: begin
                if (trap || irq_wake) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_redir) begin
            w_pc_nxt = w_target;
        end else if (w_load) begin
            w_pc_nxt = r_pc + c_INST_BYTES;
        end
    end

    always_comb begin
        w_fetch_valid_nxt = r_fetch_valid;
        if (w_redir) begin
            w_fetch_valid_nxt = 1'b0;
        end else if (w_load) begin
            w_fetch_valid_nxt = 1'b1;
        end else if (w_consume) begin
            w_fetch_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= 32'h0;
            r_fetch_inst  <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_kill        <= w_kill_nxt;
            r_fetch_valid <= w_fetch_valid_nxt;
            if (w_load) begin
                r_fetch_pc   <= r_pc;
                r_fetch_inst <= im_rdata;
            end
        end
    end

    assign im_req      = w_issue;
    assign im_addr     = (r_state == S_REQ) ? r_pc : 32'h0;
    assign fetch_pc    = r_fetch_pc;
    assign fetch_inst  = r_fetch_inst;
    assign fetch_valid = r_fetch_valid;
    assign waiting     = ~r_fetch_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed bench for if_fetch_unit with a transaction-level
//               reference model and a simple memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        trap;
    logic [31:0] mtvec;
    logic        mret;
    logic [31:0] mepc;
    logic        wfi;
    logic        irq_wake;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        fetch_valid;
    logic        waiting;

    int n_tests;
    int n_fails;

    // memory responder
    logic        gnt_en;
    int          lat;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic        force_rv;

    // reference model: boot cycle, sleep, outstanding request, output buffer
    logic        m_boot;
    logic        m_sleep;
    logic        m_out;
    logic        m_live;
    logic [31:0] m_oaddr;
    logic [31:0] m_pc;
    logic        m_bv;
    logic [31:0] m_bpc;
    logic [31:0] m_binst;

    logic [31:0] req_log[$];
    logic [31:0] cons_log[$];
    logic [31:0] inst_log[$];

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .trap        (trap),
        .mtvec       (mtvec),
        .mret        (mret),
        .mepc        (mepc),
        .wfi         (wfi),
        .irq_wake    (irq_wake),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_gnt      (im_gnt),
        .im_rvalid   (im_rvalid),
        .im_rdata    (im_rdata),
        .fetch_pc    (fetch_pc),
        .fetch_inst  (fetch_inst),
        .fetch_valid (fetch_valid),
        .waiting     (waiting)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_boot   = 1'b1;
        m_sleep  = 1'b0;
        m_out    = 1'b0;
        m_live   = 1'b0;
        m_oaddr  = 32'h0;
        m_pc     = 32'h0;
        m_bv     = 1'b0;
        m_bpc    = 32'h0;
        m_binst  = 32'h0;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        mem_addr = 32'h0;
    endtask

    task automatic clear_logs();
        req_log.delete();
        cons_log.delete();
        inst_log.delete();
    endtask

    // First half of a cycle: drive memory, then compare DUT against the model.
    task automatic prep();
        logic rphase;
        logic ereq;
        #1;
        im_gnt    = gnt_en;
        im_rvalid = force_rv | (mem_busy && mem_cnt == 0);
        im_rdata  = force_rv ? 32'hBAD0_BAD0 : mem_word(mem_addr);
        #1;
        rphase = !m_boot && !m_sleep && !m_out;
        ereq   = rphase && (!m_bv || !stall);
        chk1("im_req", im_req, ereq);
        chk("im_addr", im_addr, rphase ? m_pc : 32'h0);
        chk1("fetch_valid", fetch_valid, m_bv);
        chk1("waiting", waiting, !m_bv);
        if (m_bv) begin
            chk("fetch_pc", fetch_pc, m_bpc);
            chk("fetch_inst", fetch_inst, m_binst);
        end
        if (im_req && im_gnt) req_log.push_back(im_addr);
        if (fetch_valid && !stall) begin
            cons_log.push_back(fetch_pc);
            inst_log.push_back(fetch_inst);
        end
    endtask

    // Second half: advance model and memory by one clock, then cross the edge.
    task automatic adv();
        logic        rphase;
        logic        sel;
        logic        fire;
        logic        resp;
        logic        live_resp;
        logic        go_sleep;
        logic        wake;
        logic [31:0] tgt;
        logic [31:0] pc_old;
        rphase    = !m_boot && !m_sleep && !m_out;
        sel       = trap || mret || redirect;
        tgt       = trap ? mtvec : (mret ? mepc : redirect_pc);
        fire      = rphase && (!m_bv || !stall) && im_gnt;
        resp      = m_out && im_rvalid;
        live_resp = resp && m_live && !sel;
        go_sleep  = wfi && !sel && ((rphase && !fire) || live_resp);
        wake      = m_sleep && (trap || irq_wake);
        pc_old    = m_pc;

        if (sel) m_bv = 1'b0;
        else if (live_resp) begin
            m_bv    = 1'b1;
            m_bpc   = m_oaddr;
            m_binst = mem_word(m_oaddr);
        end else if (m_bv && !stall) m_bv = 1'b0;

        if (sel) m_pc = tgt & 32'hFFFF_FFFC;
        else if (live_resp) m_pc = m_oaddr + 32'd4;

        if (resp) m_out = 1'b0;
        else if (m_out && sel) m_live = 1'b0;
        if (fire) begin
            m_out   = 1'b1;
            m_live  = !sel;
            m_oaddr = pc_old;
        end

        if (m_sleep) m_sleep = !wake;
        else m_sleep = go_sleep;
        m_boot = 1'b0;

        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 1'b0;
            else mem_cnt--;
        end
        if (im_req && im_gnt) begin
            mem_busy = 1'b1;
            mem_cnt  = lat - 1;
            mem_addr = im_addr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            prep();
            adv();
        end
    endtask

    task automatic run_until_req(input int k, input string nm);
        int n = 0;
        while (req_log.size() < k && n < 40) begin
            prep();
            adv();
            n++;
        end
        chk1(nm, req_log.size() >= k, 1'b1);
    endtask

    task automatic run_until_cons(input int k, input string nm);
        int n = 0;
        while (cons_log.size() < k && n < 40) begin
            prep();
            adv();
            n++;
        end
        chk1(nm, cons_log.size() >= k, 1'b1);
    endtask

    task automatic wait_fetch(input logic [31:0] pc, input string nm);
        int n = 0;
        while (!(fetch_valid && fetch_pc == pc) && n < 40) begin
            prep();
            adv();
            n++;
        end
        chk1(nm, fetch_valid && fetch_pc == pc, 1'b1);
    endtask

    // Asserts reset between clock edges and checks the outputs immediately.
    task automatic do_reset();
        #2;
        rst       = 1'b0;
        stall     = 1'b0;
        redirect  = 1'b0;
        trap      = 1'b0;
        mret      = 1'b0;
        wfi       = 1'b0;
        irq_wake  = 1'b0;
        force_rv  = 1'b0;
        im_rvalid = 1'b0;
        #1;
        chk1("rst_im_req", im_req, 1'b0);
        chk("rst_im_addr", im_addr, 32'h0);
        chk("rst_fetch_pc", fetch_pc, 32'h0);
        chk("rst_fetch_inst", fetch_inst, 32'h0);
        chk1("rst_fetch_valid", fetch_valid, 1'b0);
        chk1("rst_waiting", waiting, 1'b1);
        model_reset();
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_tests     = 0;
        n_fails     = 0;
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        trap        = 1'b0;
        mtvec       = 32'h0;
        mret        = 1'b0;
        mepc        = 32'h0;
        wfi         = 1'b0;
        irq_wake    = 1'b0;
        im_gnt      = 1'b0;
        im_rvalid   = 1'b0;
        im_rdata    = 32'h0;
        gnt_en      = 1'b1;
        lat         = 1;
        force_rv    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // sequential boot fetch
        do_reset();
        run_until_cons(3, "boot_cons_timeout");
        chk("boot_req0", (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx, 32'h0);
        chk("boot_req1", (req_log.size() > 1) ? req_log[1] : 32'hxxxx_xxxx, 32'h4);
        chk("boot_req2", (req_log.size() > 2) ? req_log[2] : 32'hxxxx_xxxx, 32'h8);
        chk("boot_pc0", (cons_log.size() > 0) ? cons_log[0] : 32'hxxxx_xxxx, 32'h0);
        chk("boot_pc1", (cons_log.size() > 1) ? cons_log[1] : 32'hxxxx_xxxx, 32'h4);
        chk("boot_pc2", (cons_log.size() > 2) ? cons_log[2] : 32'hxxxx_xxxx, 32'h8);
        chk("boot_inst0", (inst_log.size() > 0) ? inst_log[0] : 32'hxxxx_xxxx, 32'hDEAD_BEEF);

        // stall for three cycles while PC 4 is presented
        do_reset();
        wait_fetch(32'h4, "stall_wait_pc4");
        stall = 1'b1;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            prep();
            chk("stall_hold_pc", fetch_pc, 32'h4);
            chk1("stall_hold_valid", fetch_valid, 1'b1);
            chk1("stall_no_req", im_req, 1'b0);
            adv();
        end
        chk1("stall_req_log_empty", req_log.size() == 0, 1'b1);
        stall = 1'b0;
        run_until_cons(2, "stall_cons_timeout");
        chk("stall_next_req", (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx, 32'h8);
        chk("stall_next_pc", (cons_log.size() > 1) ? cons_log[1] : 32'hxxxx_xxxx, 32'h8);

        // branch redirect while the PC-8 response is in flight
        do_reset();
        run_until_req(3, "br_req_timeout");
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        prep();
        adv();
        redirect = 1'b0;
        clear_logs();
        chk1("br_valid_cleared", fetch_valid, 1'b0);
        run_until_req(1, "br_target_timeout");
        chk("br_target_addr", (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx, 32'h100);
        chk1("br_no_consume_between", cons_log.size() == 0, 1'b1);
        run_until_cons(1, "br_cons_timeout");
        chk("br_target_pc", (cons_log.size() > 0) ? cons_log[0] : 32'hxxxx_xxxx, 32'h100);
        chk("br_target_inst", (inst_log.size() > 0) ? inst_log[0] : 32'hxxxx_xxxx, 32'hDEAD_BFEF);

        // mret beats branch; redirect before rvalid kills the outstanding fetch
        lat = 3;
        clear_logs();
        run_until_req(1, "kill_req_timeout");
        mret        = 1'b1;
        mepc        = 32'h0000_0303;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0500;
        prep();
        adv();
        mret     = 1'b0;
        redirect = 1'b0;
        clear_logs();
        run_until_req(1, "kill_target_timeout");
        chk("kill_target_addr", (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx, 32'h300);
        chk1("kill_no_consume", cons_log.size() == 0, 1'b1);
        lat = 1;

        // trap beats branch; target shown while the request is not granted
        gnt_en = 1'b0;
        run(3);
        trap        = 1'b1;
        mtvec       = 32'h0000_0200;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0700;
        prep();
        adv();
        trap     = 1'b0;
        redirect = 1'b0;
        prep();
        chk("trap_addr_ungranted", im_addr, 32'h200);
        chk1("trap_req_ungranted", im_req, 1'b1);
        adv();
        gnt_en = 1'b1;
        clear_logs();
        run_until_req(1, "trap_req_timeout");
        chk("trap_req_addr", (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx, 32'h200);

        // wfi at PC 0x10, wake by interrupt
        do_reset();
        run_until_req(5, "wfi_req_timeout");
        chk("wfi_last_req", (req_log.size() > 4) ? req_log[4] : 32'hxxxx_xxxx, 32'h10);
        wfi = 1'b1;
        clear_logs();
        run(6);
        chk1("wfi_no_req", req_log.size() == 0, 1'b1);
        chk("wfi_buffered_pc", (cons_log.size() > 0) ? cons_log[0] : 32'hxxxx_xxxx, 32'h10);
        wfi      = 1'b0;
        irq_wake = 1'b1;
        prep();
        adv();
        irq_wake = 1'b0;
        run_until_req(1, "wake_req_timeout");
        chk("wake_req_addr", (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx, 32'h14);

        // address wrap at the top of memory
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        prep();
        adv();
        redirect = 1'b0;
        clear_logs();
        run_until_req(2, "wrap_req_timeout");
        run_until_cons(1, "wrap_cons_timeout");
        chk("wrap_req0", (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
        chk("wrap_req1", (req_log.size() > 1) ? req_log[1] : 32'hxxxx_xxxx, 32'h0);
        chk("wrap_pc", (cons_log.size() > 0) ? cons_log[0] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
        chk("wrap_inst", (inst_log.size() > 0) ? inst_log[0] : 32'hxxxx_xxxx, 32'h2152_4113);

        // reset mid-transaction, then a stale response before the first grant
        lat = 3;
        clear_logs();
        run_until_req(1, "midrst_req_timeout");
        run(1);
        do_reset();
        lat      = 1;
        force_rv = 1'b1;
        prep();
        adv();
        prep();
        adv();
        force_rv = 1'b0;
        run_until_cons(1, "midrst_cons_timeout");
        chk("midrst_req0", (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx, 32'h0);
        chk("midrst_pc0", (cons_log.size() > 0) ? cons_log[0] : 32'hxxxx_xxxx, 32'h0);
        chk("midrst_inst0", (inst_log.size() > 0) ? inst_log[0] : 32'hxxxx_xxxx, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
